// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: CPU word, owner encoding and defaults.
package ram_port_arbiter_pkg;

    typedef logic [31:0] cpu_word;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2
    } ram_owner_e;

    localparam int unsigned RAM_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Fetch, data and RAM-side signals of the arbiter; slave = arbiter view, master = core/RAM view.
interface ram_port_arbiter_if;
    import ram_port_arbiter_pkg::*;

    logic    if_req;
    cpu_word if_addr;
    logic    if_gnt;
    logic    if_rvalid;
    cpu_word if_rdata;

    logic    d_req;
    logic    d_we;
    cpu_word d_addr;
    cpu_word d_wdata;
    logic    d_gnt;
    logic    d_rvalid;
    cpu_word d_rdata;

    cpu_word mem_addr;
    logic    mem_we;
    cpu_word mem_wdata;
    cpu_word mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/ram_port_arbiter_starve_counter.sv
// Saturating starvation counter: counts denied fetch cycles, hit marks the force-grant point.
module ram_starve_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit = (cnt_q == CNT_W'(LIMIT));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch and load/store; data has priority,
// fetch is force-granted after STARVE_LIMIT denied cycles.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = RAM_STARVE_LIMIT_DEFAULT,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   bus
);

    logic             if_gnt;
    logic             d_gnt;
    logic             force_if;
    logic             starve_hit;
    logic [CNT_W-1:0] starve_cnt;

    ram_owner_e owner_q, owner_d;
    logic       if_rvalid_q, if_rvalid_d;
    logic       d_rvalid_q, d_rvalid_d;
    cpu_word    if_hold_q, if_hold_d;
    cpu_word    d_hold_q, d_hold_d;

    assign force_if = bus.if_req && starve_hit;
    assign if_gnt   = bus.if_req && (!bus.d_req || force_if);
    assign d_gnt    = bus.d_req && !if_gnt;

    assign bus.if_gnt = if_gnt;
    assign bus.d_gnt  = d_gnt;

    ram_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.if_req && !if_gnt),
        .clr   (if_gnt || !bus.if_req),
        .cnt   (starve_cnt),
        .hit   (starve_hit)
    );

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    // RAM data arrives in the response cycle, so rdata forwards mem_rdata then and holds afterwards.
    always_comb begin
        owner_d = OWNER_NONE;
        if (if_gnt) begin
            owner_d = OWNER_IF;
        end else if (d_gnt && !bus.d_we) begin
            owner_d = OWNER_D;
        end
        if_rvalid_d = (owner_d == OWNER_IF);
        d_rvalid_d  = (owner_d == OWNER_D);
        if_hold_d   = (owner_q == OWNER_IF) ? bus.mem_rdata : if_hold_q;
        d_hold_d    = (owner_q == OWNER_D)  ? bus.mem_rdata : d_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWNER_NONE;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_hold_q   <= '0;
            d_hold_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_hold_q   <= if_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : if_hold_q;
    assign bus.d_rdata   = d_rvalid_q  ? bus.mem_rdata : d_hold_q;

endmodule
